// File: rtl/rand_button_pkg.sv
// Shared types and helpers for the pseudo-random push-button emulator.
package rand_button_pkg;

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_RELEASED,
      ST_BOUNCE_DN,
      ST_PRESSED,
      ST_BOUNCE_UP
   } state_e;

   localparam logic [31:0] GOLDEN = 32'h9E37_79B9;

   function automatic logic [31:0] xorshift32(input logic [31:0] x);
      logic [31:0] v;
      v = x ^ (x << 13);
      v = v ^ (v >> 17);
      v = v ^ (v << 5);
      return v;
   endfunction

   // Per-channel seed; an all-zero xorshift state would never leave zero.
   function automatic logic [31:0] chan_seed(input logic [31:0] base, input int unsigned idx);
      logic [31:0] s;
      s = base ^ (GOLDEN * idx);
      return (s == 32'd0) ? 32'd1 : s;
   endfunction

endpackage

// File: rtl/rand_button_channel.sv
// One emulated button: press/hold/release FSM with contact bounce, duration timer and private PRNG.
module rand_button_channel
   import rand_button_pkg::*;
#(
   parameter int          CNT_W         = 16,
   parameter int          IDLE_MIN      = 100,
   parameter int          IDLE_LOG2     = 10,
   parameter int          HOLD_MIN      = 50,
   parameter int          HOLD_LOG2     = 8,
   parameter int          BOUNCE_EVENTS = 4,
   parameter int          BOUNCE_LOG2   = 3,
   parameter logic [31:0] SEED_INIT     = 32'h1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        seed_load,
   input  logic [31:0] seed_ch,
   output logic        btn,
   output logic        btn_clean,
   output logic        press_pulse,
   output logic        release_pulse
);

   localparam int BC_W = (BOUNCE_EVENTS > 2) ? $clog2(BOUNCE_EVENTS) : 1;

   state_e             state, state_nx;
   logic [CNT_W-1:0]   timer, timer_nx;
   logic [BC_W-1:0]    bcnt, bcnt_nx;
   logic [31:0]        prng, prng_nx, r;
   logic               btn_nx, clean_nx, press_nx, release_nx;
   logic               enter_bounce, enter_press, enter_release;

   function automatic logic [CNT_W-1:0] span(input logic [31:0] r_val, input int unsigned base,
                                             input int unsigned lg);
      logic [31:0] mask;
      mask = (32'd1 << lg) - 32'd1;
      return CNT_W'(base) + CNT_W'(r_val & mask);
   endfunction

   always_comb begin
      r             = xorshift32(prng);
      state_nx      = state;
      timer_nx      = timer;
      bcnt_nx       = bcnt;
      prng_nx       = prng;
      btn_nx        = btn;
      clean_nx      = btn_clean;
      press_nx      = 1'b0;
      release_nx    = 1'b0;
      enter_bounce  = 1'b0;
      enter_press   = 1'b0;
      enter_release = 1'b0;
      case (state)
         ST_LOAD: begin
            prng_nx  = r;
            timer_nx = span(r, IDLE_MIN, IDLE_LOG2);
            state_nx = ST_RELEASED;
         end
         ST_RELEASED: begin
            if (timer != '0) timer_nx = timer - CNT_W'(1);
            else if (en) begin
               if (BOUNCE_EVENTS > 0) enter_bounce = 1'b1;
               else                   enter_press  = 1'b1;
            end
         end
         ST_BOUNCE_DN, ST_BOUNCE_UP: begin
            if (timer != '0) timer_nx = timer - CNT_W'(1);
            else if (bcnt != '0) begin
               btn_nx   = ~btn;
               bcnt_nx  = bcnt - BC_W'(1);
               prng_nx  = r;
               timer_nx = span(r, 0, BOUNCE_LOG2);
            end
            else if (state == ST_BOUNCE_DN) enter_press   = 1'b1;
            else                            enter_release = 1'b1;
         end
         ST_PRESSED: begin
            if (timer != '0) timer_nx = timer - CNT_W'(1);
            else if (BOUNCE_EVENTS > 0) enter_bounce  = 1'b1;
            else                        enter_release = 1'b1;
         end
         default: state_nx = ST_LOAD;
      endcase

      // The timer holds interval-1 during bounce so each contact level lasts the drawn interval.
      if (enter_bounce) begin
         state_nx = (state == ST_RELEASED) ? ST_BOUNCE_DN : ST_BOUNCE_UP;
         btn_nx   = (state == ST_RELEASED);
         clean_nx = (state == ST_RELEASED);
         bcnt_nx  = BC_W'((BOUNCE_EVENTS > 0) ? BOUNCE_EVENTS - 1 : 0);
         prng_nx  = r;
         timer_nx = span(r, 0, BOUNCE_LOG2);
      end
      if (enter_press) begin
         state_nx = ST_PRESSED;
         btn_nx   = 1'b1;
         clean_nx = 1'b1;
         press_nx = 1'b1;
         prng_nx  = r;
         timer_nx = span(r, HOLD_MIN, HOLD_LOG2);
      end
      if (enter_release) begin
         state_nx   = ST_RELEASED;
         btn_nx     = 1'b0;
         clean_nx   = 1'b0;
         release_nx = 1'b1;
         prng_nx    = r;
         timer_nx   = span(r, IDLE_MIN, IDLE_LOG2);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_LOAD;
         timer         <= '0;
         bcnt          <= '0;
         prng          <= SEED_INIT;
         btn           <= 1'b0;
         btn_clean     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else if (seed_load) begin
         state         <= ST_LOAD;
         timer         <= '0;
         bcnt          <= '0;
         prng          <= seed_ch;
         btn           <= 1'b0;
         btn_clean     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         state         <= state_nx;
         timer         <= timer_nx;
         bcnt          <= bcnt_nx;
         prng          <= prng_nx;
         btn           <= btn_nx;
         btn_clean     <= clean_nx;
         press_pulse   <= press_nx;
         release_pulse <= release_nx;
      end
   end

endmodule

// File: rtl/rand_button_emulator.sv
// N_CH independent pseudo-random push-buttons with bounce, reproducible from a common seed.
module rand_button_emulator
   import rand_button_pkg::*;
#(
   parameter int          N_CH          = 4,
   parameter int          CNT_W         = 16,
   parameter int          IDLE_MIN      = 100,
   parameter int          IDLE_LOG2     = 10,
   parameter int          HOLD_MIN      = 50,
   parameter int          HOLD_LOG2     = 8,
   parameter int          BOUNCE_EVENTS = 4,
   parameter int          BOUNCE_LOG2   = 3,
   parameter logic [31:0] DEFAULT_SEED  = 32'h0000_04D2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            seed_load,
   input  logic [31:0]     seed,
   output logic [N_CH-1:0] btn,
   output logic [N_CH-1:0] btn_clean,
   output logic [N_CH-1:0] press_pulse,
   output logic [N_CH-1:0] release_pulse
);

   localparam longint IDLE_MAX = longint'(IDLE_MIN) + (longint'(1) << IDLE_LOG2) - 1;
   localparam longint HOLD_MAX = longint'(HOLD_MIN) + (longint'(1) << HOLD_LOG2) - 1;
   localparam longint CNT_MAX  = (longint'(1) << CNT_W) - 1;

   if (IDLE_MAX > CNT_MAX || HOLD_MAX > CNT_MAX) begin : g_cnt_w_check
      $error("rand_button_emulator: CNT_W too narrow for idle/hold durations");
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [31:0] ch_seed;
      assign ch_seed = chan_seed(seed, i);

      rand_button_channel #(
         .CNT_W         (CNT_W),
         .IDLE_MIN      (IDLE_MIN),
         .IDLE_LOG2     (IDLE_LOG2),
         .HOLD_MIN      (HOLD_MIN),
         .HOLD_LOG2     (HOLD_LOG2),
         .BOUNCE_EVENTS (BOUNCE_EVENTS),
         .BOUNCE_LOG2   (BOUNCE_LOG2),
         .SEED_INIT     (chan_seed(DEFAULT_SEED, i))
      ) u_ch (
         .clk           (clk),
         .rst_n         (rst_n),
         .en            (en),
         .seed_load     (seed_load),
         .seed_ch       (ch_seed),
         .btn           (btn[i]),
         .btn_clean     (btn_clean[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i])
      );
   end

endmodule

// File: tb/tb_rand_button_emulator.sv
// Bench for rand_button_emulator: three configurations checked cycle by cycle against a timeline model.
module tb_rand_button_emulator;
   import rand_button_pkg::*;

   localparam int NS = 9;
   localparam int IMIN [3] = '{3, 3, 5};
   localparam int ILOG [3] = '{4, 4, 5};
   localparam int HMIN [3] = '{5, 4, 3};
   localparam int HLOG [3] = '{3, 3, 4};
   localparam int BEV  [3] = '{0, 4, 3};
   localparam int BLOG [3] = '{3, 0, 2};
   localparam logic [31:0] DEF_SEED = 32'h0000_04D2;

   logic        clk = 1'b0;
   logic        rst_n, en, seed_load;
   logic [31:0] seed;
   logic [0:0]  btn_a, clean_a, pp_a, rp_a;
   logic [3:0]  btn_b, clean_b, pp_b, rp_b;
   logic [3:0]  btn_c, clean_c, pp_c, rp_c;
   logic [8:0]  all_btn, all_clean, all_pp, all_rp;

   assign all_btn   = {btn_c, btn_b, btn_a};
   assign all_clean = {clean_c, clean_b, clean_a};
   assign all_pp    = {pp_c, pp_b, pp_a};
   assign all_rp    = {rp_c, rp_b, rp_a};

   always #5 clk = ~clk;

   rand_button_emulator #(.N_CH(1), .IDLE_MIN(3), .IDLE_LOG2(4), .HOLD_MIN(5), .HOLD_LOG2(3),
                          .BOUNCE_EVENTS(0), .BOUNCE_LOG2(3)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed(seed),
      .btn(btn_a), .btn_clean(clean_a), .press_pulse(pp_a), .release_pulse(rp_a));

   rand_button_emulator #(.N_CH(4), .IDLE_MIN(3), .IDLE_LOG2(4), .HOLD_MIN(4), .HOLD_LOG2(3),
                          .BOUNCE_EVENTS(4), .BOUNCE_LOG2(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed(seed),
      .btn(btn_b), .btn_clean(clean_b), .press_pulse(pp_b), .release_pulse(rp_b));

   rand_button_emulator #(.N_CH(4), .IDLE_MIN(5), .IDLE_LOG2(5), .HOLD_MIN(3), .HOLD_LOG2(4),
                          .BOUNCE_EVENTS(3), .BOUNCE_LOG2(2)) dut_c (
      .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed(seed),
      .btn(btn_c), .btn_clean(clean_c), .press_pulse(pp_c), .release_pulse(rp_c));

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] mx   [NS];
   logic [3:0]  mq   [NS][$];
   logic [3:0]  expv [NS];
   logic [8:0]  tr1  [300];
   logic [8:0]  tr2  [300];
   logic [2:0]  t1_exp [10] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                                3'b111, 3'b110, 3'b110, 3'b110, 3'b110};
   logic [2:0]  t2_exp [10] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                                3'b110, 3'b010, 3'b110, 3'b010, 3'b111};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   function automatic int dut_of(input int s);
      return (s == 0) ? 0 : ((s < 5) ? 1 : 2);
   endfunction

   function automatic int ch_of(input int s);
      return (s == 0) ? 0 : (s - 1) % 4;
   endfunction

   // Each draw advances the channel's generator and returns the low lg bits of the new state.
   function automatic int draw_span(input int s, input int lg);
      mx[s] = xorshift32(mx[s]);
      return int'(mx[s] & ((32'd1 << lg) - 32'd1));
   endfunction

   task automatic push(input int s, input logic [3:0] v, input int n);
      for (int k = 0; k < n; k++) mq[s].push_back(v);
   endtask

   // Queue holds {btn, clean, press, release} for the coming edges: the load edge then the idle span.
   task automatic restart(input int s, input logic [31:0] base);
      logic [31:0] v;
      int          d;
      d = dut_of(s);
      v = base ^ (32'h9E37_79B9 * 32'(ch_of(s)));
      if (v == 32'd0) v = 32'd1;
      mx[s] = v;
      mq[s].delete();
      push(s, 4'b0000, 1 + IMIN[d] + draw_span(s, ILOG[d]));
   endtask

   task automatic episode(input int s);
      int   d;
      logic b;
      d = dut_of(s);
      b = 1'b1;
      for (int k = 0; k < BEV[d]; k++) begin
         push(s, {b, 3'b100}, 1 + draw_span(s, BLOG[d]));
         b = ~b;
      end
      push(s, 4'b1110, 1);
      push(s, 4'b1100, HMIN[d] + draw_span(s, HLOG[d]));
      b = 1'b0;
      for (int k = 0; k < BEV[d]; k++) begin
         push(s, {b, 3'b000}, 1 + draw_span(s, BLOG[d]));
         b = ~b;
      end
      push(s, 4'b0001, 1);
      push(s, 4'b0000, IMIN[d] + draw_span(s, ILOG[d]));
   endtask

   task automatic model_edge();
      for (int s = 0; s < NS; s++) begin
         if (!rst_n) begin
            restart(s, DEF_SEED);
            expv[s] = 4'b0000;
         end else if (seed_load) begin
            restart(s, seed);
            expv[s] = 4'b0000;
         end else begin
            if (mq[s].size() == 0) begin
               if (en) episode(s);
               else    mq[s].push_back(4'b0000);
            end
            expv[s] = mq[s].pop_front();
         end
      end
   endtask

   task automatic check_all(input string tag);
      for (int s = 0; s < NS; s++)
         check($sformatf("%s_slot%0d", tag, s),
               {28'd0, all_btn[s], all_clean[s], all_pp[s], all_rp[s]}, {28'd0, expv[s]});
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      #1;
      model_edge();
      check_all(tag);
   endtask

   initial begin
      int   diff;
      logic found, prev_clean;

      rst_n = 1'b0; en = 1'b0; seed_load = 1'b0; seed = 32'd0;
      for (int s = 0; s < NS; s++) begin
         restart(s, DEF_SEED);
         expv[s] = 4'b0000;
      end
      #3;
      check_all("reset");
      repeat (2) step("reset");
      #2 rst_n = 1'b1;

      // en low from reset: nothing may ever press
      repeat (120) step("en_off");
      check("en_off_btn", {23'd0, all_btn}, 32'd0);

      // seed 1: first draw gives idle 4, press on the 6th edge; dut_b bounces with interval 1
      seed = 32'd1; seed_load = 1'b1;
      step("load1");
      seed_load = 1'b0; en = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step("seq");
         check($sformatf("nobounce_e%0d", k + 1), {29'd0, btn_a, clean_a, pp_a}, {29'd0, t1_exp[k]});
         check($sformatf("bounce_e%0d", k + 1), {29'd0, btn_b[0], clean_b[0], pp_b[0]},
               {29'd0, t2_exp[k]});
      end

      // random enable with long low bursts
      for (int i = 0; i < 800; i++) begin
         en = (((i / 60) % 4) != 3) && ($urandom_range(0, 7) != 0);
         step("random");
      end

      // reproducibility with the same seed
      en = 1'b1;
      seed = 32'hDEAD_BEEF; seed_load = 1'b1; step("rep_a"); seed_load = 1'b0;
      for (int i = 0; i < 300; i++) begin step("rep_a"); tr1[i] = all_btn; end
      seed = 32'hDEAD_BEEF; seed_load = 1'b1; step("rep_b"); seed_load = 1'b0;
      diff = 0;
      for (int i = 0; i < 300; i++) begin
         step("rep_b");
         tr2[i] = all_btn;
         check($sformatf("rep_same_%0d", i), {23'd0, tr2[i]}, {23'd0, tr1[i]});
         if (tr1[i][6] != tr1[i][5]) diff++;
      end
      check("ch1_differs_ch0", 32'(diff > 0), 32'd1);

      // seed 0 must behave as seed 1 on channel 0
      seed = 32'd1; seed_load = 1'b1; step("seed1"); seed_load = 1'b0;
      for (int i = 0; i < 300; i++) begin step("seed1"); tr1[i] = all_btn; end
      seed = 32'd0; seed_load = 1'b1; step("seed0"); seed_load = 1'b0;
      for (int i = 0; i < 300; i++) begin
         step("seed0");
         tr2[i] = all_btn;
         check($sformatf("seed0_ch0_%0d", i), {29'd0, tr2[i][5], tr2[i][1], tr2[i][0]},
               {29'd0, tr1[i][5], tr1[i][1], tr1[i][0]});
      end

      // abort a press with seed_load
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin step("wait_press"); found = pp_b[0]; end
      check("press_seen", {31'd0, found}, 32'd1);
      step("hold");
      seed = $urandom; seed_load = 1'b1; step("abort"); seed_load = 1'b0;
      check("abort_btn", {30'd0, btn_b[0], rp_b[0]}, 32'd0);
      repeat (3) begin
         step("after_abort");
         check("no_release_pulse", {31'd0, rp_b[0]}, 32'd0);
      end

      // asynchronous reset in the middle of a release bounce
      found = 1'b0;
      prev_clean = clean_b[0];
      for (int i = 0; i < 400 && !found; i++) begin
         step("wait_bounce_up");
         found = prev_clean && !clean_b[0];
         prev_clean = clean_b[0];
      end
      check("bounce_up_seen", {31'd0, found}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      for (int s = 0; s < NS; s++) begin
         restart(s, DEF_SEED);
         expv[s] = 4'b0000;
      end
      check_all("async_reset");
      repeat (2) step("in_reset");
      #2 rst_n = 1'b1;
      for (int i = 0; i < 300; i++) begin
         en = ($urandom_range(0, 5) != 0);
         step("post_reset");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
